// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer
// Description : Control-path sequencer for one convolutional layer instance.
//               Accepts an upstream pixel stream (valid/ready), generates
//               one layer clock-enable per accepted pixel, presents each
//               valid layer result downstream (valid/ready) while holding
//               the layer frozen, and counts pixels/results per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 5,
  parameter int STRIDE      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  output logic layer_clk_en,
  input  logic layer_valid,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic frame_done,
  output logic count_error
);

  // --------------------------------------------------------------------------
  // Frame geometry
  // --------------------------------------------------------------------------
  localparam int TOTAL_PIX = IMAGE_SIZE * IMAGE_SIZE;
  localparam int OUT_DIM   = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int EXP_OUT   = OUT_DIM * OUT_DIM;
  localparam int PIX_W     = $clog2(TOTAL_PIX + 1);
  localparam int OUT_W     = $clog2(EXP_OUT + 1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL_PIX);
  localparam logic [OUT_W-1:0] OUT_EXP  = OUT_W'(EXP_OUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_EVAL   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [PIX_W-1:0] pix_cnt_d;
  logic [OUT_W-1:0] out_cnt_q;
  logic [OUT_W-1:0] out_cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             count_error_q;
  logic             pix_last;

  // Last pixel of the frame has been accepted; decides EVAL/EMIT exit.
  assign pix_last = (pix_cnt_q == PIX_LAST);

  // Saturating increments: the counters must never wrap inside a frame, even
  // if the layer misbehaves and produces more results than expected.
  assign pix_cnt_d = (pix_cnt_q == PIX_LAST) ? pix_cnt_q : pix_cnt_q + 1'b1;
  assign out_cnt_d = (out_cnt_q == {OUT_W{1'b1}}) ? out_cnt_q : out_cnt_q + 1'b1;

  // The layer only advances on an accepted pixel, so it is frozen everywhere
  // else (in particular while a result waits in EMIT).
  assign layer_clk_en = in_valid & in_ready_q;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign count_error = count_error_q;

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (in_valid) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (layer_valid) begin
          state_d = ST_EMIT;
        end else if (pix_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = pix_last ? ST_DONE : ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they are valid in the same cycle as the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pix_cnt_q     <= '0;
      out_cnt_q     <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      count_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == ST_STREAM);
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pix_cnt_q <= '0;
            out_cnt_q <= '0;
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            pix_cnt_q <= pix_cnt_d;
          end
        end
        ST_EVAL: begin
          if (layer_valid) begin
            out_valid_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_cnt_q   <= out_cnt_d;
          end
        end
        ST_DONE: begin
          // Sticky until reset; a later clean frame does not clear it.
          if (out_cnt_q != OUT_EXP) begin
            count_error_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_sequencer
// Description : Self-checking bench for conv_layer_sequencer: a short table of
//               per-cycle vectors followed by full-frame sequences driven by a
//               small layer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic in_valid;
  logic in_ready;
  logic layer_clk_en;
  logic layer_valid;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic frame_done;
  logic count_error;

  int checks   = 0;
  int failures = 0;

  conv_layer_sequencer #(
    .IMAGE_SIZE (28),
    .FILTER_SIZE(5),
    .STRIDE     (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .layer_clk_en(layer_clk_en),
    .layer_valid (layer_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .count_error (count_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       iv;
    logic       lv;
    logic       ordy;
    logic [4:0] exp_o;   // {in_ready, layer_clk_en, out_valid, busy, frame_done}
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Layer model: a result exists for pixel index r*28+c when r>=4 and c>=4.
  // With drop set, the final pixel yields no result (575 results total).
  function automatic bit qual(input int idx, input bit drop);
    int r;
    int c;
    r = idx / 28;
    c = idx % 28;
    return (r >= 4) && (c >= 4) && !(drop && idx == 783);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; layer_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs one frame from IDLE. Returns counts of clock-enable pulses, result
  // transfers, frame_done pulses, cycles held by backpressure, protocol
  // violations and busy one cycle after frame_done.
  task automatic run_frame(input bit hold, input bit drop, input bit toggle,
                           input bit inject, input int abort_at,
                           output int pulses, output int xfers, output int dones,
                           output int held, output int viol, output int busy_after);
    int acc;
    int last;
    int hold_left;
    bit hold_armed;
    bit prev_ov;
    bit prev_or;
    bit prev_ce;
    bit seen_done;
    bit aborted;
    acc = 0; last = -1; hold_left = 10; hold_armed = hold;
    prev_ov = 0; prev_or = 0; prev_ce = 0; seen_done = 0; aborted = 0;
    pulses = 0; xfers = 0; dones = 0; held = 0; viol = 0; busy_after = 1;
    for (int cy = 0; cy < 6000 && !seen_done; cy++) begin
      @(posedge clk); #1;
      if (abort_at > 0 && acc == abort_at) begin
        aborted = 1;
        break;
      end
      start       = (cy == 0) || (inject && (acc == 100 || acc == 784));
      in_valid    = toggle ? (cy % 2 == 1) : 1'b1;
      layer_valid = (last >= 0) && qual(last, drop);
      out_ready   = !(hold_armed && out_valid && hold_left > 0);
      #2;
      if (layer_clk_en !== (in_valid & in_ready)) viol++;
      if (layer_clk_en && prev_ce) viol++;
      if (prev_ov && !prev_or && !out_valid) viol++;
      if (out_valid && in_ready) viol++;
      if (layer_clk_en) begin
        last = acc;
        acc++;
        pulses++;
      end
      if (out_valid && out_ready) xfers++;
      if (hold_armed && out_valid && !out_ready) begin
        held++;
        if (in_ready || layer_clk_en) viol++;
        hold_left--;
        if (hold_left == 0) hold_armed = 0;
      end
      if (frame_done) begin
        dones++;
        seen_done = 1;
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_ce = layer_clk_en;
    end
    if (aborted) begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b1; layer_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      chk("abort_outputs_zero",
          {in_ready, layer_clk_en, out_valid, busy, frame_done, count_error}, 0);
      busy_after = busy;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #3;
        if (frame_done) dones++;
        if (busy || layer_clk_en) viol++;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; layer_valid = 1'b1; out_ready = 1'b1;
        #2;
        if (k == 0) busy_after = busy;
        if (frame_done) dones++;
        if (layer_clk_en || out_valid) viol++;
      end
    end
  endtask

  initial begin
    int p, x, d, h, v, b;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; layer_valid = 1'b0; out_ready = 1'b0;

    //            st  iv  lv  ordy exp {ir,ce,ov,busy,fd}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};  // idle after reset
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};  // start; pixel not taken in IDLE
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10010};  // STREAM waiting
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b11010};  // accept; out_ready ignored
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00010};  // EVAL, no result
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11010};  // layer_valid ignored in STREAM
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00010};  // EVAL with result
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00110};  // EMIT, backpressured
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00110};  // EMIT, still held
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b00110};  // EMIT taken
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10010};  // start ignored in STREAM
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10010};  // still streaming

    do_reset();
    #2;
    chk("reset_outputs",
        {in_ready, layer_clk_en, out_valid, busy, frame_done, count_error}, 0);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = tbl[i].st; in_valid = tbl[i].iv; layer_valid = tbl[i].lv; out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("vec%0d", i),
          {in_ready, layer_clk_en, out_valid, busy, frame_done}, tbl[i].exp_o);
    end

    // Mid-frame reset from the table trace.
    do_reset();
    #2;
    chk("midframe_reset",
        {in_ready, layer_clk_en, out_valid, busy, frame_done, count_error}, 0);

    // Clean frame, full throughput.
    run_frame(0, 0, 0, 0, 0, p, x, d, h, v, b);
    chk("clean_pulses", p, 784);
    chk("clean_xfers", x, 576);
    chk("clean_dones", d, 1);
    chk("clean_viol", v, 0);
    chk("clean_busy_after", b, 0);
    chk("clean_count_error", count_error, 0);

    // Backpressure for 10 cycles on the first result.
    run_frame(1, 0, 0, 0, 0, p, x, d, h, v, b);
    chk("hold_cycles", h, 10);
    chk("hold_pulses", p, 784);
    chk("hold_xfers", x, 576);
    chk("hold_viol", v, 0);
    chk("hold_dones", d, 1);

    // Short frame: one result missing sets a sticky error.
    run_frame(0, 1, 0, 0, 0, p, x, d, h, v, b);
    chk("short_xfers", x, 575);
    chk("short_dones", d, 1);
    chk("short_count_error", count_error, 1);
    run_frame(0, 0, 0, 0, 0, p, x, d, h, v, b);
    chk("sticky_xfers", x, 576);
    chk("sticky_count_error", count_error, 1);

    // Reset at pixel 300, then a full frame.
    run_frame(0, 0, 0, 0, 300, p, x, d, h, v, b);
    chk("abort_pulses", p, 300);
    chk("abort_dones", d, 0);
    chk("abort_viol", v, 0);
    run_frame(0, 0, 0, 0, 0, p, x, d, h, v, b);
    chk("after_abort_pulses", p, 784);
    chk("after_abort_xfers", x, 576);
    chk("after_abort_count_error", count_error, 0);

    // start pulsed in STREAM and in the DONE cycle.
    run_frame(0, 0, 0, 1, 0, p, x, d, h, v, b);
    chk("inject_pulses", p, 784);
    chk("inject_xfers", x, 576);
    chk("inject_dones", d, 1);
    chk("inject_busy_after", b, 0);

    // in_valid toggling every cycle.
    run_frame(0, 0, 1, 0, 0, p, x, d, h, v, b);
    chk("toggle_pulses", p, 784);
    chk("toggle_xfers", x, 576);
    chk("toggle_viol", v, 0);
    chk("toggle_dones", d, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
